// File: rtl/qspi_pkg.sv
// Shared types and constants for the single-lane serial-flash read sequencer.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    HOLD,
    GAP
  } seq_state_e;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_READ4B    = 8'h13;

  localparam int unsigned TMR_W = 16;
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/qspi_cs_timer.sv
// Loadable down-counter for chip-select guard times; expire pulses in the
// cycle the count reaches one, so a load of N expires N cycles after loading.
module qspi_cs_timer
  import qspi_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/qspi_flash_read_sequencer.sv
// Drives one x1 flash read (cmd, address, dummy, data) through a byte-wide
// transceiver, owning chip select and its setup/hold/idle guard times.
module qspi_flash_read_sequencer
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 3,
  parameter logic [7:0]  READ_CMD    = OP_READ,
  parameter int unsigned DUMMY_BYTES = 0,
  parameter int unsigned CS_SETUP    = 2,
  parameter int unsigned CS_HOLD     = 2,
  parameter int unsigned CS_IDLE     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        cs_n,
  output logic        shift_en,
  output logic [7:0]  tx_data,
  input  logic        shift_done,
  input  logic [7:0]  rx_data
);

  // Left-justify the used address bytes so the MSB byte is always [31:24].
  localparam int unsigned ADDR_SHIFT = 32 - 8 * ADDR_BYTES;

  seq_state_e state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_sr;
  logic [15:0]      len_q;

  logic             shift_issue;
  logic [7:0]       tx_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             addr_adv;
  logic             start_take;
  logic             cs_fall;
  logic             cs_rise;
  logic             done_set;
  logic             rx_take;
  logic             addr_end;
  logic             dummy_end;
  logic             data_end;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;

  qspi_cs_timer #(
    .W(TMR_W)
  ) u_cs_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_issue = 1'b0;
    tx_nxt      = 8'h00;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    addr_adv    = 1'b0;
    start_take  = 1'b0;
    cs_fall     = 1'b0;
    cs_rise     = 1'b0;
    done_set    = 1'b0;
    rx_take     = 1'b0;
    addr_end    = 1'b0;
    dummy_end   = 1'b0;
    data_end    = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state)
      IDLE: begin
        if (start) begin
          start_take = 1'b1;
          cs_fall    = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(CS_SETUP);
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (tmr_expire) begin
          shift_issue = 1'b1;
          tx_nxt      = READ_CMD;
          state_nxt   = CMD;
        end
      end
      CMD: begin
        if (shift_done) begin
          shift_issue = 1'b1;
          tx_nxt      = addr_sr[31:24];
          addr_adv    = 1'b1;
          cnt_load    = 1'b1;
          cnt_val     = CNT_W'(ADDR_BYTES);
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (shift_done) begin
          if (cnt == CNT_W'(1)) begin
            addr_end = 1'b1;
          end else begin
            shift_issue = 1'b1;
            tx_nxt      = addr_sr[31:24];
            addr_adv    = 1'b1;
            cnt_dec     = 1'b1;
          end
        end
      end
      DUMMY: begin
        if (shift_done) begin
          if (cnt == CNT_W'(1)) begin
            dummy_end = 1'b1;
          end else begin
            shift_issue = 1'b1;
            cnt_dec     = 1'b1;
          end
        end
      end
      DATA: begin
        if (shift_done) begin
          rx_take = 1'b1;
          if (cnt == CNT_W'(1)) begin
            data_end = 1'b1;
          end else begin
            shift_issue = 1'b1;
            cnt_dec     = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tmr_expire) begin
          cs_rise   = 1'b1;
          done_set  = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(CS_IDLE);
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Phase hand-off: skip empty dummy/data phases straight to the next one.
    if (addr_end && (DUMMY_BYTES != 0)) begin
      shift_issue = 1'b1;
      cnt_load    = 1'b1;
      cnt_val     = CNT_W'(DUMMY_BYTES);
      state_nxt   = DUMMY;
    end else if ((addr_end || dummy_end) && (len_q != 16'd0)) begin
      shift_issue = 1'b1;
      cnt_load    = 1'b1;
      cnt_val     = len_q;
      state_nxt   = DATA;
    end else if (addr_end || dummy_end || data_end) begin
      tmr_load  = 1'b1;
      tmr_val   = TMR_W'(CS_HOLD);
      state_nxt = HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n     <= 1'b1;
      shift_en <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      cnt      <= '0;
    end else begin
      shift_en <= shift_issue;
      done     <= done_set;
      rd_valid <= rx_take;
      if (shift_issue) begin
        tx_data <= tx_nxt;
      end
      if (rx_take) begin
        rd_data <= rx_data;
      end
      if (cs_fall) begin
        cs_n <= 1'b0;
      end else if (cs_rise) begin
        cs_n <= 1'b1;
      end
      if (cnt_load) begin
        cnt <= cnt_val;
      end else if (cnt_dec) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Request operands are pure data and need no reset.
  always_ff @(posedge clk) begin
    if (start_take) begin
      addr_sr <= addr << ADDR_SHIFT;
      len_q   <= len;
    end else if (addr_adv) begin
      addr_sr <= addr_sr << 8;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_qspi_flash_read_sequencer.sv
// Directed bench: two sequencer instances (plain READ, and FAST_READ with a
// 4-byte address and one dummy byte) each driven by a fixed-latency transceiver model.
module tb_qspi_flash_read_sequencer;
  import qspi_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start;
  logic [31:0] addr [2];
  logic [15:0] len [2];
  logic [1:0]  shift_done = 2'b00;
  logic [7:0]  rx_data [2] = '{8'h00, 8'h00};

  wire [1:0]  busy, done, rd_valid, cs_n, shift_en;
  wire [7:0]  rd_data [2];
  wire [7:0]  tx_data [2];

  qspi_flash_read_sequencer dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .addr(addr[0]), .len(len[0]),
    .busy(busy[0]), .done(done[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .cs_n(cs_n[0]), .shift_en(shift_en[0]), .tx_data(tx_data[0]),
    .shift_done(shift_done[0]), .rx_data(rx_data[0])
  );

  qspi_flash_read_sequencer #(
    .ADDR_BYTES(4), .READ_CMD(OP_FAST_READ), .DUMMY_BYTES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .addr(addr[1]), .len(len[1]),
    .busy(busy[1]), .done(done[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .cs_n(cs_n[1]), .shift_en(shift_en[1]), .tx_data(tx_data[1]),
    .shift_done(shift_done[1]), .rx_data(rx_data[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transceiver model: shift_done LAT+1 edges after shift_en is sampled.
  int         bcnt [2] = '{0, 0};
  int         bidx [2] = '{0, 0};
  int         tx_n [2] = '{0, 0};
  logic [7:0] tx_log [2][64];
  logic [7:0] rx_tab [2][64];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      shift_done[g] <= 1'b0;
      if (bcnt[g] > 0) begin
        bcnt[g] <= bcnt[g] - 1;
        if (bcnt[g] == 1) begin
          shift_done[g] <= 1'b1;
          rx_data[g]    <= rx_tab[g][bidx[g]];
        end
      end
      if (shift_en[g]) begin
        bcnt[g] <= LAT;
        bidx[g] <= tx_n[g];
        if (tx_n[g] < 64) tx_log[g][tx_n[g]] <= tx_data[g];
        tx_n[g] <= tx_n[g] + 1;
      end
    end
  end

  int         rd_n [2] = '{0, 0};
  int         done_n [2] = '{0, 0};
  int         rise_n [2] = '{0, 0};
  int         done_cyc [2], fall_cyc [2], first_se_cyc [2], last_sd_cyc [2], hi_time [2];
  int         rise_cyc [2] = '{0, 0};
  logic [7:0] rd_log [2][64];
  logic       prev_cs [2] = '{1'b1, 1'b1};
  logic       se_pend [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd_valid[g] === 1'b1) begin
        if (rd_n[g] < 64) rd_log[g][rd_n[g]] <= rd_data[g];
        rd_n[g] <= rd_n[g] + 1;
      end
      if (done[g] === 1'b1) begin
        done_n[g]   <= done_n[g] + 1;
        done_cyc[g] <= cyc;
      end
      if (shift_done[g]) last_sd_cyc[g] <= cyc;
      if (prev_cs[g] && cs_n[g] === 1'b0) begin
        fall_cyc[g] <= cyc;
        hi_time[g]  <= cyc - rise_cyc[g];
        se_pend[g]  <= 1'b1;
      end
      if (!prev_cs[g] && cs_n[g] === 1'b1) begin
        rise_cyc[g] <= cyc;
        rise_n[g]   <= rise_n[g] + 1;
      end
      if (se_pend[g] && shift_en[g] === 1'b1) begin
        first_se_cyc[g] <= cyc;
        se_pend[g]      <= 1'b0;
      end
      prev_cs[g] <= (cs_n[g] !== 1'b0);
    end
  end

  int checks = 0;
  int errors = 0;
  int start_cyc [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int g, input logic [31:0] a, input logic [15:0] l);
    tick();
    addr[g]      = a;
    len[g]       = l;
    start[g]     = 1'b1;
    start_cyc[g] = cyc;
    tick();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int d0);
    int n = 0;
    while (done_n[g] == d0 && n < 400) begin
      tick();
      n++;
    end
    check_eq($sformatf("done_seen%0d", g), 32'(done_n[g] - d0), 32'd1);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check_eq($sformatf("idle%0d", g), 32'(busy[g]), 32'd0);
  endtask

  task automatic check_tx(input int g, input int b, input logic [7:0] e [8], input int n);
    check_eq($sformatf("tx_count%0d", g), 32'(tx_n[g] - b), 32'(n));
    for (int i = 0; i < n; i++)
      check_eq($sformatf("tx%0d_%0d", g, i), 32'(tx_log[g][b + i]), 32'(e[i]));
  endtask

  task automatic check_guard(input int g);
    check_eq($sformatf("cs_setup%0d", g), 32'(first_se_cyc[g] - fall_cyc[g]), 32'd2);
    check_eq($sformatf("cs_hold%0d", g), 32'(rise_cyc[g] - last_sd_cyc[g] - 1), 32'd2);
  endtask

  initial begin
    int b, r, d, rr;
    logic [7:0] e [8];

    rst   = 1'b1;
    start = 2'b00;
    for (int g = 0; g < 2; g++) begin
      addr[g] = '0;
      len[g]  = '0;
      for (int i = 0; i < 64; i++) rx_tab[g][i] = 8'hEE;
    end
    repeat (3) tick();

    check_eq("rst_cs_n", 32'(cs_n[0]), 32'd1);
    check_eq("rst_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_done", 32'(done[0]), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data[0]), 32'd0);
    check_eq("rst_shift_en", 32'(shift_en[0]), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data[0]), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic read, len=2
    b = tx_n[0]; r = rd_n[0]; d = done_n[0]; rr = rise_n[0];
    rx_tab[0][b + 4] = 8'hA5;
    rx_tab[0][b + 5] = 8'h5A;
    run(0, 32'h0012_3456, 16'd2);
    wait_done(0, d);
    e = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    check_tx(0, b, e, 6);
    check_eq("basic_rd_count", 32'(rd_n[0] - r), 32'd2);
    check_eq("basic_rd0", 32'(rd_log[0][r]), 32'hA5);
    check_eq("basic_rd1", 32'(rd_log[0][r + 1]), 32'h5A);
    check_eq("basic_cs_rises", 32'(rise_n[0] - rr), 32'd1);
    check_eq("basic_cs_rise_at_done", 32'(rise_cyc[0]), 32'(done_cyc[0]));
    check_eq("basic_latency", 32'(done_cyc[0] - start_cyc[0]), 32'd35);
    check_guard(0);
    repeat (3) tick();
    check_eq("basic_done_once", 32'(done_n[0] - d), 32'd1);
    wait_idle(0);

    // len=0: command and address only
    b = tx_n[0]; r = rd_n[0]; d = done_n[0];
    run(0, 32'h00FE_DCBA, 16'd0);
    wait_done(0, d);
    e = '{8'h03, 8'hFE, 8'hDC, 8'hBA, 8'h00, 8'h00, 8'h00, 8'h00};
    check_tx(0, b, e, 4);
    check_eq("len0_no_rd", 32'(rd_n[0] - r), 32'd0);
    check_eq("len0_latency", 32'(done_cyc[0] - start_cyc[0]), 32'd25);
    check_guard(0);

    // Start one cycle after done lands in GAP and is dropped
    b = tx_n[0]; d = done_n[0];
    run(0, 32'h0000_0001, 16'd1);
    wait_idle(0);
    check_eq("gap_start_dropped_tx", 32'(tx_n[0] - b), 32'd0);
    check_eq("gap_start_dropped_cs", 32'(cs_n[0]), 32'd1);
    check_eq("gap_start_dropped_done", 32'(done_n[0] - d), 32'd0);
    r = rd_n[0];
    rx_tab[0][b + 4] = 8'h3C;
    run(0, 32'h0000_0001, 16'd1);
    wait_done(0, d);
    check_eq("b2b_cs_high_min", 32'(hi_time[0] >= 4), 32'd1);
    check_eq("b2b_rd", 32'(rd_log[0][r]), 32'h3C);
    check_eq("b2b_latency", 32'(done_cyc[0] - start_cyc[0]), 32'd30);
    wait_idle(0);

    // Reset after the 2nd of 4 data bytes
    b = tx_n[0]; r = rd_n[0]; d = done_n[0];
    rx_tab[0][b + 4] = 8'h11;
    rx_tab[0][b + 5] = 8'h22;
    rx_tab[0][b + 6] = 8'h33;
    rx_tab[0][b + 7] = 8'h44;
    run(0, 32'h0000_0010, 16'd4);
    begin
      int n = 0;
      while (rd_n[0] - r < 2 && n < 400) begin
        tick();
        n++;
      end
    end
    check_eq("mid_rd_reached", 32'(rd_n[0] - r), 32'd2);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
    check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
    check_eq("mid_rst_shift_en", 32'(shift_en[0]), 32'd0);
    check_eq("mid_rst_rd_data", 32'(rd_data[0]), 32'd0);
    rst = 1'b0;
    repeat (20) tick();
    check_eq("mid_no_done", 32'(done_n[0] - d), 32'd0);
    check_eq("mid_no_more_rd", 32'(rd_n[0] - r), 32'd2);
    check_eq("mid_tx_count", 32'(tx_n[0] - b), 32'd7);
    check_eq("mid_rd0", 32'(rd_log[0][r]), 32'h11);
    check_eq("mid_rd1", 32'(rd_log[0][r + 1]), 32'h22);

    // Fresh transaction after the abort
    b = tx_n[0]; r = rd_n[0]; d = done_n[0];
    rx_tab[0][b + 4] = 8'hC3;
    run(0, 32'h00AB_CDEF, 16'd1);
    wait_done(0, d);
    e = '{8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00};
    check_tx(0, b, e, 5);
    check_eq("post_rd_count", 32'(rd_n[0] - r), 32'd1);
    check_eq("post_rd", 32'(rd_log[0][r]), 32'hC3);
    check_eq("post_latency", 32'(done_cyc[0] - start_cyc[0]), 32'd30);
    check_guard(0);

    // FAST_READ, 4 address bytes, one dummy byte
    b = tx_n[1]; r = rd_n[1]; d = done_n[1];
    rx_tab[1][b + 5] = 8'h77;
    rx_tab[1][b + 6] = 8'h9C;
    run(1, 32'h89AB_CDEF, 16'd1);
    wait_done(1, d);
    e = '{8'h0B, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00};
    check_tx(1, b, e, 7);
    check_eq("fast_rd_count", 32'(rd_n[1] - r), 32'd1);
    check_eq("fast_rd", 32'(rd_log[1][r]), 32'h9C);
    check_eq("fast_latency", 32'(done_cyc[1] - start_cyc[1]), 32'd40);
    check_guard(1);

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_flash_read_sequencer.md
Name: qspi_flash_read_sequencer

Overview:
- Sequences one single-lane (x1) serial-flash read transaction on top of the byte-wide QSPI host transceiver.
- Transaction order: assert chip select, shift the command byte, then the address bytes, then the dummy bytes, then N data bytes; stream the read bytes out; deassert chip select with setup, hold and idle guard times.
- Sits between a boot loader or register-mapped flash controller and the transceiver, which does not manage chip select itself.

Parameters:
- ADDR_BYTES, 3: address bytes sent MSB first; legal values are 3 or 4.
- READ_CMD, 8'h03: command opcode sent first.
- DUMMY_BYTES, 0: number of 8'h00 bytes shifted after the address; their received data is discarded. Range 0-15.
- CS_SETUP, 2: clk cycles from cs_n falling to the first shift_en. Minimum 1.
- CS_HOLD, 2: clk cycles from the last shift_done to cs_n rising. Minimum 1.
- CS_IDLE, 4: minimum clk cycles cs_n stays high before the next transaction can start. Minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- addr  in  32  start address; only the low ADDR_BYTES*8 bits are used
- len  in  16  number of data bytes; 0 means command/address/dummy only
- busy  out  1  high from the cycle after start is accepted until the cycle the sequencer returns to IDLE
- done  out  1  one-cycle pulse when the transaction completes
- rd_valid  out  1  one-cycle pulse per received data byte
- rd_data  out  8  received byte; valid only when rd_valid is high
- cs_n  out  1  flash chip select, active low
- shift_en  out  1  one-cycle pulse to the transceiver to start a byte shift
- tx_data  out  8  byte to transmit; held stable from shift_en until shift_done
- shift_done  in  1  transceiver byte-complete pulse
- rx_data  in  8  transceiver received byte; valid when shift_done is high

Behaviour:
- Reset values: cs_n=1, busy=0, done=0, rd_valid=0, rd_data=0, shift_en=0, tx_data=0. State goes to IDLE and all counters clear.
- Reset mid-transaction: cs_n rises on the next edge. No done pulse, no further rd_valid. A shift_done from the aborted shift is ignored.
- States and transitions:
  - IDLE: on start, latch addr and len, set cs_n=0, set busy=1, go to SETUP.
  - SETUP: count CS_SETUP cycles, then issue shift_en with tx_data=READ_CMD and go to CMD.
  - CMD: on shift_done, go to ADDR.
  - ADDR: issue ADDR_BYTES shifts, MSB byte first.
  - DUMMY: issue DUMMY_BYTES shifts with tx_data=8'h00; skipped when DUMMY_BYTES=0.
  - DATA: issue len shifts with tx_data=8'h00; skipped when len=0.
  - HOLD: count CS_HOLD cycles, then set cs_n=1 and pulse done.
  - GAP: count CS_IDLE cycles, then go to IDLE with busy=0.
- Shift handshake:
  - Exactly one shift is outstanding at a time.
  - The next shift_en is issued in the cycle after the previous shift_done is seen, so there is one idle clk between bytes.
  - shift_en is never asserted in the same cycle as shift_done.
  - shift_done is ignored in IDLE, SETUP, HOLD and GAP.
- Data output: rd_valid is asserted in the cycle after each DATA-phase shift_done, with rd_data equal to the registered rx_data. There is no backpressure; the consumer must accept every byte.
- Counters:
  - Byte counter is 16 bits and down-counts. DATA ends when the counter reaches 0 after a shift_done.
  - len=16'hFFFF gives 65535 bytes with no wrap.
- start while busy or in GAP is dropped silently; it is not queued.
- Latency for len=1, ADDR_BYTES=3, DUMMY_BYTES=0 is 1 + CS_SETUP + 5 shifts (each shift plus 1 gap cycle) + CS_HOLD cycles from start to done.

Decomposition:
- Package qspi_pkg holds:
  - the state enum (IDLE, SETUP, CMD, ADDR, DUMMY, DATA, HOLD, GAP);
  - constants for common opcodes: READ 8'h03, FAST_READ 8'h0B, READ4B 8'h13.
- One sub-module, qspi_cs_timer: a small loadable down-counter shared by SETUP, HOLD and GAP, outputting an expiry pulse.
- The transceiver is instantiated by the parent, not inside this block.

Test Plan:
- Basic read: start with addr=32'h00123456 and len=2, transceiver model returning 8'hA5 then 8'h5A.
  - tx sequence is 03,12,34,56,00,00.
  - rd_valid fires twice with A5 then 5A.
  - cs_n stays low throughout; done fires once.
- len=0: tx sequence is 03,12,34,56 only, with no rd_valid, then done after CS_HOLD cycles.
- DUMMY_BYTES=1, READ_CMD=8'h0B, len=1: tx is 0B,addr,00,00. Only the final byte produces rd_valid.
- Back-to-back: a second start one cycle after done is dropped. A start issued after CS_IDLE cycles is accepted, and cs_n high time is at least CS_IDLE.
- Reset mid-DATA: assert rst after the 2nd of 4 data bytes.
  - cs_n=1 on the next cycle, no done, and a late shift_done is ignored.
  - A new transaction then completes correctly.
- Timing checks: cs_n fall to first shift_en equals CS_SETUP, and last shift_done to cs_n rise equals CS_HOLD.
